// File: rtl/output_requant_pkg.sv
// Shared types and constants for the output requantisation buffer.
// Holds the run FSM states, int8 clamp limits and pipeline widths.
package output_requant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int INT8_MIN   = -128;
    localparam int INT8_MAX   = 127;
    localparam int ACC_W      = 24;
    localparam int SCALE_W    = 16;
    localparam int S1_W       = ACC_W + 1;
    localparam int S2_W       = S1_W + SCALE_W;
    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/requant_lane.sv
// One lane: bias add, scale, round-half-up shift, int8 clamp.
// ReLU clamping is built only with OUTPUT_REQUANT_RELU_EN defined.
module requant_lane
    import output_requant_pkg::*;
#(
    parameter int dataSize  = 8,
    parameter int accSize   = ACC_W,
    parameter int scaleSize = SCALE_W,
    parameter int shiftSize = 5,
    parameter int s1Size    = S1_W,
    parameter int s2Size    = S2_W
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [accSize-1:0]   acc_i,
    input  logic [accSize-1:0]   bias_i,
    input  logic [scaleSize-1:0] scale_i,
    input  logic [shiftSize-1:0] shift_i,
    input  logic                 relu_i,
    output logic [dataSize-1:0]  res_o
);

    localparam int RW = s2Size + 1;

    logic signed [s1Size-1:0] sum_q, sum_d;
    logic [scaleSize-1:0]     scale_q, scale_d;
    logic [shiftSize-1:0]     sh1_q, sh1_d;
    logic [shiftSize-1:0]     sh2_q, sh2_d;
    logic signed [s2Size-1:0] prod_q, prod_d;
    logic [dataSize-1:0]      res_q, res_d;
    logic signed [s2Size-1:0] op_a, op_b;
    logic signed [RW-1:0]     half, rnd, shd, lo, hi;
    logic                     relu_s3;

`ifdef OUTPUT_REQUANT_RELU_EN
    logic [1:0] relu_q, relu_d;

    always_comb relu_d = {relu_q[0], relu_i};

    always_ff @(posedge clk) begin
        if (!nrst) relu_q <= '0;
        else       relu_q <= relu_d;
    end

    assign relu_s3 = relu_q[1];
`else
    logic relu_unused;

    assign relu_unused = relu_i;
    assign relu_s3     = 1'b0;
`endif

    always_comb begin
        sum_d   = $signed({acc_i[accSize-1], acc_i})
                + $signed({bias_i[accSize-1], bias_i});
        scale_d = scale_i;
        sh1_d   = shift_i;

        op_a   = {{(s2Size-s1Size){sum_q[s1Size-1]}}, sum_q};
        op_b   = {{(s2Size-scaleSize){1'b0}}, scale_q};
        prod_d = op_a * op_b;
        sh2_d  = sh1_q;

        // Extra headroom bit keeps the rounding add from wrapping.
        half = '0;
        if (sh2_q != '0) half = RW'(1) << (sh2_q - 1'b1);
        rnd = {prod_q[s2Size-1], prod_q} + half;
        shd = rnd >>> sh2_q;
        hi  = RW'(INT8_MAX);
`ifdef OUTPUT_REQUANT_RELU_EN
        lo = relu_s3 ? '0 : RW'(INT8_MIN);
`else
        lo = RW'(INT8_MIN);
`endif
        if (shd > hi)      res_d = hi[dataSize-1:0];
        else if (shd < lo) res_d = lo[dataSize-1:0];
        else               res_d = shd[dataSize-1:0];
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sum_q   <= '0;
            scale_q <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            scale_q <= scale_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/output_requant_buffer.sv
// Deskews array columns, requantises each lane and fills the output buffer.
// Define OUTPUT_REQUANT_RELU_EN to honour cfg_relu in the lanes.
module output_requant_buffer
    import output_requant_pkg::*;
#(
    parameter int dataSize      = 8,
    parameter int accSize       = ACC_W,
    parameter int numOutChannel = 3,
    parameter int numRegister   = 256,
    parameter int scaleSize     = SCALE_W,
    parameter int shiftSize     = 5
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic [accSize*numOutChannel-1:0]   acc_in,
    input  logic                               acc_valid,
    input  logic [accSize*numOutChannel-1:0]   cfg_bias,
    input  logic [scaleSize-1:0]               cfg_scale,
    input  logic [shiftSize-1:0]               cfg_shift,
    input  logic                               cfg_relu,
    input  logic [15:0]                        cfg_num_pixels,
    input  logic                               ctrl_start,
    input  logic [$clog2(numRegister)-1:0]     rd_addr,
    output logic [dataSize*numOutChannel-1:0]  rd_data,
    output logic                               flag_done,
    output logic                               flag_overflow
);

    localparam int AW = $clog2(numRegister);
    localparam int PW = AW + 1;
    localparam int NC = numOutChannel;
    localparam int WW = dataSize * NC;
    localparam int VD = NC - 1;

    state_e                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           num_q, num_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic [VD-1:0]         vd_q, vd_d;
    logic [PIPE_DEPTH-1:0] pv_q, pv_d;
    logic [WW-1:0]         rd_data_q, rd_data_d;
    logic [WW-1:0]         wr_word;
    logic                  wr_en;
    logic                  vin;
    logic [WW-1:0]         mem_q [numRegister];

    for (genvar c = 0; c < NC; c++) begin : g_lane
        localparam int D = NC - 1 - c;
        logic [accSize-1:0] acc_al;

        if (D == 0) begin : g_pass
            assign acc_al = acc_in[c*accSize +: accSize];
        end else begin : g_dly
            logic [accSize-1:0] sr_q [D];
            logic [accSize-1:0] sr_d [D];

            always_comb begin
                sr_d[0] = acc_in[c*accSize +: accSize];
                for (int i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
            end

            always_ff @(posedge clk) begin
                if (!nrst) begin
                    for (int i = 0; i < D; i++) sr_q[i] <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign acc_al = sr_q[D-1];
        end

        requant_lane #(
            .dataSize  (dataSize),
            .accSize   (accSize),
            .scaleSize (scaleSize),
            .shiftSize (shiftSize),
            .s1Size    (accSize + 1),
            .s2Size    (accSize + 1 + scaleSize)
        ) u_lane (
            .clk     (clk),
            .nrst    (nrst),
            .acc_i   (acc_al),
            .bias_i  (cfg_bias[c*accSize +: accSize]),
            .scale_i (cfg_scale),
            .shift_i (cfg_shift),
            .relu_i  (cfg_relu),
            .res_o   (wr_word[c*dataSize +: dataSize])
        );
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        rd_data_d = mem_q[rd_addr];

        vin     = acc_valid && (state_q == ST_RUN) && !ctrl_start;
        vd_d[0] = vin;
        for (int i = 1; i < VD; i++) vd_d[i] = vd_q[i-1];
        pv_d = {pv_q[PIPE_DEPTH-2:0], vd_q[VD-1]};

        // A start in any state opens a fresh run and drops in-flight pixels.
        if (ctrl_start) begin
            state_d  = ST_RUN;
            wr_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            num_d    = cfg_num_pixels;
            vd_d     = '0;
            pv_d     = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (cnt_q == num_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (pv_q[PIPE_DEPTH-1]) begin
                        cnt_d = cnt_q + 16'd1;
                        if (wr_ptr_q == PW'(numRegister)) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            num_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            vd_q      <= '0;
            pv_q      <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            vd_q      <= vd_d;
            pv_q      <= pv_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end

    assign rd_data       = rd_data_q;
    assign flag_done     = done_q;
    assign flag_overflow = ovf_q;

endmodule

// File: tb/tb_output_requant_buffer.sv
// Directed bench for output_requant_buffer (16-entry buffer, 3 lanes).
// Expected ReLU result follows OUTPUT_REQUANT_RELU_EN.
module tb_output_requant_buffer;

    localparam int NC   = 3;
    localparam int AW   = 24;
    localparam int NREG = 16;
    localparam int RA   = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic [AW*NC-1:0] acc_in;
    logic             acc_valid;
    logic [AW*NC-1:0] cfg_bias;
    logic [15:0]      cfg_scale;
    logic [4:0]       cfg_shift;
    logic             cfg_relu;
    logic [15:0]      cfg_num_pixels;
    logic             ctrl_start;
    logic [RA-1:0]    rd_addr;
    logic [8*NC-1:0]  rd_data;
    logic             flag_done;
    logic             flag_overflow;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int exp_done = 0;
    int v0, w0;
    int px [32][3];
    logic [23:0] relu_exp;

    output_requant_buffer #(
        .numRegister (NREG)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .acc_in         (acc_in),
        .acc_valid      (acc_valid),
        .cfg_bias       (cfg_bias),
        .cfg_scale      (cfg_scale),
        .cfg_shift      (cfg_shift),
        .cfg_relu       (cfg_relu),
        .cfg_num_pixels (cfg_num_pixels),
        .ctrl_start     (ctrl_start),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .flag_done      (flag_done),
        .flag_overflow  (flag_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flag_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] sat8(input int v);
        if (v > 127)  return 8'h7f;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    function automatic logic [23:0] w3(input int a0, input int a1, input int a2);
        return {sat8(a2), sat8(a1), sat8(a0)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int b0, input int b1, input int b2,
                           input int sc, input int sh, input logic rl);
        cfg_bias  = {24'(b2), 24'(b1), 24'(b0)};
        cfg_scale = 16'(sc);
        cfg_shift = 5'(sh);
        cfg_relu  = rl;
    endtask

    task automatic start_run(input int num);
        cfg_num_pixels = 16'(num);
        ctrl_start = 1'b1;
        step(1);
        ctrl_start = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_addr = RA'(addr);
        step(1);
    endtask

    // Column c carries pixel j at cycle j+c.
    task automatic drive_pixels(input int n, output int first);
        int j, v;
        first = cyc;
        for (int k = 0; k < n + NC - 1; k++) begin
            acc_valid = (k < n);
            for (int c = 0; c < NC; c++) begin
                j = k - c;
                v = (j >= 0 && j < n) ? px[j][c] : 0;
                acc_in[c*AW +: AW] = 24'(v);
            end
            step(1);
        end
        acc_valid = 1'b0;
        acc_in = '0;
    endtask

    initial begin
        nrst = 1'b0;
        acc_in = '0;
        acc_valid = 1'b0;
        ctrl_start = 1'b0;
        cfg_num_pixels = '0;
        rd_addr = '0;
        set_cfg(0, 0, 0, 1, 0, 1'b0);
        step(3);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_done", 32'(flag_done), 0);
        check("rst_ovf", 32'(flag_overflow), 0);
        nrst = 1'b1;
        step(2);

        // Zero-length run
        v0 = cyc;
        start_run(0);
        step(3);
        exp_done++;
        check("zero_done_cnt", done_cnt, exp_done);
        check("zero_done_cyc", done_cyc, v0 + 2);

        // Single non-saturating pixel
        set_cfg(0, 0, 0, 1, 0, 1'b0);
        px[0] = '{100, -50, 7};
        start_run(1);
        drive_pixels(1, v0);
        step(5);
        exp_done++;
        check("single_done_cnt", done_cnt, exp_done);
        check("single_done_cyc", done_cyc, v0 + 7);
        rd(0);
        check("single_word", 32'(rd_data), 32'h07ce64);

        // Rounding + saturation, write latency, read-old-on-write
        set_cfg(24, 24, 24, 3, 4, 1'b0);
        px[0] = '{1000, 10, -1000};
        rd_addr = '0;
        start_run(1);
        drive_pixels(1, v0);
        step(3);
        check("lat_old_data", 32'(rd_data), 32'h07ce64);
        step(1);
        check("round_sat_word", 32'(rd_data), 32'h80067f);
        step(1);
        exp_done++;
        check("round_done_cyc", done_cyc, v0 + 7);

        // Negative rounding, clamp to -128
        set_cfg(0, 0, 0, 1, 1, 1'b0);
        px[0] = '{-300, -3, 5};
        start_run(1);
        drive_pixels(1, v0);
        step(5);
        exp_done++;
        rd(0);
        check("neg_round_word", 32'(rd_data), 32'h03ff80);

        // ReLU
        set_cfg(0, 0, 0, 1, 0, 1'b1);
        px[0] = '{-5, 20, -1};
        start_run(1);
        drive_pixels(1, v0);
        step(5);
        exp_done++;
        rd(0);
`ifdef OUTPUT_REQUANT_RELU_EN
        relu_exp = 24'h001400;
`else
        relu_exp = 24'hff14fb;
`endif
        check("relu_word", 32'(rd_data), 32'(relu_exp));

        // Ten back-to-back pixels with per-lane bias
        set_cfg(5, -5, 0, 1, 0, 1'b0);
        for (int i = 0; i < 10; i++) px[i] = '{13*i - 40, 30*i, -20*i};
        start_run(10);
        drive_pixels(10, v0);
        step(5);
        exp_done++;
        check("stream_done_cnt", done_cnt, exp_done);
        check("stream_done_cyc", done_cyc, v0 + 16);
        for (int i = 0; i < 10; i++) begin
            rd(i);
            check($sformatf("stream_word%0d", i), 32'(rd_data),
                  32'(w3(13*i - 35, 30*i - 5, -20*i)));
        end

        // Overflow: 18 pixels into 16 entries
        set_cfg(0, 0, 0, 1, 0, 1'b0);
        for (int i = 0; i < 18; i++) px[i] = '{i, i + 50, -i};
        start_run(18);
        drive_pixels(18, v0);
        step(1);
        check("ovf_before", 32'(flag_overflow), 0);
        step(1);
        check("ovf_set", 32'(flag_overflow), 1);
        step(3);
        exp_done++;
        check("ovf_done_cnt", done_cnt, exp_done);
        check("ovf_done_cyc", done_cyc, v0 + 24);
        rd(0);
        check("ovf_word0", 32'(rd_data), 32'(w3(0, 50, 0)));
        rd(15);
        check("ovf_word15", 32'(rd_data), 32'(w3(15, 65, -15)));

        // Synchronous reset in the middle of a run
        start_run(20);
        drive_pixels(18, v0);
        step(3);
        check("rrst_ovf_pre", 32'(flag_overflow), 1);
        rd(1);
        check("rrst_word1", 32'(rd_data), 32'(w3(1, 51, -1)));
        nrst = 1'b0;
        step(1);
        check("rrst_rd_data", 32'(rd_data), 0);
        check("rrst_done", 32'(flag_done), 0);
        check("rrst_ovf", 32'(flag_overflow), 0);
        nrst = 1'b1;
        step(10);
        check("rrst_no_done", done_cnt, exp_done);

        // Restart after two of five pixels
        for (int i = 0; i < 5; i++) px[i] = '{i + 1, 2*(i + 1), 3*(i + 1)};
        start_run(5);
        drive_pixels(5, v0);
        for (int i = 0; i < 2; i++) px[i] = '{-4*(i + 1), 77, i};
        start_run(2);
        drive_pixels(2, w0);
        step(5);
        exp_done++;
        check("rs_done_cnt", done_cnt, exp_done);
        check("rs_done_cyc", done_cyc, w0 + 8);
        rd(0);
        check("rs_word0", 32'(rd_data), 32'(w3(-4, 77, 0)));
        rd(1);
        check("rs_word1", 32'(rd_data), 32'(w3(-8, 77, 1)));
        rd(2);
        check("rs_word2", 32'(rd_data), 32'(w3(2, 52, -2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_requant_buffer.md
Name: output_requant_buffer

Overview:
- Downstream stage of the systolic TPU system. Consumes the per-column 24-bit accumulator outputs and realigns them into one word per output pixel.
- Each lane applies requantisation: bias, scale, rounding shift, then clamp to int8.
- Packs the int8 results into a register-file output buffer. The buffer has a host read port and a done flag.
- Sits between the TPU array output and the host/next-layer ifmap writer.

Parameters:
- dataSize, 8: output element width (int8).
- accSize, 24: accumulator input width; matches the PE output width.
- numOutChannel, 3: number of array columns (lanes).
- numRegister, 256: output buffer depth in words.
- scaleSize, 16: unsigned requant multiplier width.
- shiftSize, 5: right-shift amount width.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- acc_in  in  accSize x numOutChannel  column outputs. Column c is skewed: it lags column 0 by c cycles.
- acc_valid  in  1  qualifies acc_in column 0 for one pixel.
- cfg_bias  in  accSize x numOutChannel  signed per-lane bias.
- cfg_scale  in  scaleSize  unsigned multiplier, shared by all lanes.
- cfg_shift  in  shiftSize  arithmetic right-shift amount.
- cfg_relu  in  1  clamp negatives to 0.
- cfg_num_pixels  in  16  number of pixels to collect per run.
- ctrl_start  in  1  one-cycle pulse that starts a run.
- rd_addr  in  $clog2(numRegister)  host read address.
- rd_data  out  dataSize*numOutChannel  packed word, lane 0 in the LSBs. Registered.
- flag_done  out  1  one-cycle pulse when the run completes.
- flag_overflow  out  1  sticky; set when a pixel arrives with the buffer full.

Behaviour:
- Reset values: all outputs 0, wr_ptr 0, pixel counter 0, pipeline valids 0, buffer contents undefined. Mid-run reset aborts the run immediately; no done pulse follows.
- Deskew:
  - Lane c's data is delayed by (numOutChannel-1-c) cycles.
  - acc_valid is delayed by numOutChannel-1 cycles.
  - The aligned pixel therefore appears numOutChannel-1 cycles after acc_valid.
- Requant pipeline, 3 registered stages per lane:
  - S1: sum = acc + bias, accSize+1 bits signed.
  - S2: prod = sum * scale, scale zero-extended, accSize+1+scaleSize bits signed.
  - S3: res = (prod + (shift ? 1<<(shift-1) : 0)) >>> shift, i.e. round-half-up. Then clamp to [-128,127], or to [0,127] when relu applies.
- Config sampling: config inputs are sampled with each pixel at S1 and may change between pixels.
- Buffer write: the packed word is written at the cycle after S3, to address wr_ptr. wr_ptr then increments.
- End-to-end latency: acc_valid to buffer write is numOutChannel-1+4 cycles.
- FSM states IDLE, RUN, DONE:
  - IDLE: acc_valid ignored (not deskewed, not written). ctrl_start goes to RUN; it clears wr_ptr, the pixel counter and flag_overflow, and latches cfg_num_pixels.
  - RUN: each buffer write increments the counter. When counter == latched count, go to DONE. A latched count of 0 goes to DONE on the next cycle.
  - DONE: flag_done = 1 for exactly one cycle, then IDLE.
- ctrl_start during RUN or DONE restarts the run:
  - Clears pointers and pipeline valids; in-flight pixels are discarded.
  - No flag_done for the aborted run.
- Full buffer: a write with wr_ptr == numRegister is dropped and sets flag_overflow. The counter still increments so done is still reached. wr_ptr never wraps.
- Read: rd_data = buf[rd_addr] one cycle later. A read and write to the same address in one cycle returns the old data.
- acc_valid is sampled every cycle. Back-to-back pixels are sustained at 1 per cycle; there is no backpressure.

Optional Feature:
- Macro OUTPUT_REQUANT_RELU_EN.
- Defined: cfg_relu is honoured per the clamp rule above.
- Undefined: cfg_relu is ignored, clamping is always signed [-128,127], and the relu compare logic is not built.

Decomposition:
- Package output_requant_pkg holds:
  - the FSM state enum;
  - constants for the int8 min/max (-128, 127) and the S1/S2 intermediate widths;
  - the pipeline depth constant (3).
- Natural sub-module requant_lane: one lane's S1–S3 pipeline plus clamp, instantiated numOutChannel times.

Test Plan:
- Single pixel, non-saturating:
  - Stimulus: acc {100,-50,7}, bias 0, scale 1, shift 0, relu 0, num_pixels 1.
  - Required response: buffer[0] = {7,-50,100} packed; flag_done 1 cycle after the write; write lands 6 cycles after acc_valid.
- Rounding and saturation:
  - Stimulus: acc 1000, bias 24, scale 3, shift 4 → (3072+8)>>>4 = 192. Also acc -300, scale 1, shift 1.
  - Required response: 192 clamps to 127; the second pixel gives -150, which clamps to -128.
- ReLU (macro defined): acc -5, cfg_relu 1 → 0. With the macro undefined, the same stimulus → -5.
- Streaming: 10 back-to-back pixels with num_pixels 10 → buffer[0..9] match the model; flag_done exactly once, 1 cycle after the 10th write.
- Overflow: numRegister 4, 6 pixels → entries 0..3 are written; flag_overflow set at pixel 5; done still pulses after pixel 6.
- Restart: ctrl_start mid-run after 2 of 5 pixels → no done for the first run; wr_ptr restarts at 0. Sync reset during RUN → all outputs 0 on the next edge.
